gmii_frame_tx: RTL and testbench

// - Parametrised GMII frame transmitter replacing the fixed-pattern GMII sender; feeds util_gmii_to_rgmii.
// - Takes payload bytes (dst MAC .. end of payload) on a valid/ready/last stream.
// - Adds preamble, SFD, optional min-size padding, CRC-32 FCS and inter-frame gap; flags underrun/oversize via gmii_tx_er.

---
 rtl/gmii_pkg.sv | 21 ++
 rtl/crc32_d8.sv | 21 ++
 rtl/gmii_frame_tx.sv | 211 +++++++++++++++++++++
 tb/tb_gmii_frame_tx.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gmii_pkg.sv
// Shared types and constants for the GMII frame transmitter.
package gmii_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_IFG,
        ST_DROP
    } tx_state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC32_POLY_R  = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam int          MIN_PAYLOAD   = 60;

endpackage

// File: rtl/crc32_d8.sv
// One-byte step of the reflected CRC-32 (Ethernet FCS); purely combinational.
module crc32_d8
    import gmii_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    // Fold the byte in LSB first, one polynomial division step per bit.
    always_comb begin
        c = crc_in ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_R) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/gmii_frame_tx.sv
// GMII frame transmitter: wraps a payload stream with preamble, SFD, optional
// minimum-size padding, CRC-32 FCS and inter-frame gap. Underrun and oversize
// abort the frame with a single tx_er cycle.
// Build option: define GMII_TX_PAD_EN to pad short frames with 0x00 up to 60
// payload bytes before the FCS.
// State meaning: each state computes what goes on the wire in the NEXT cycle,
// since all GMII outputs are registered.
module gmii_frame_tx
    import gmii_pkg::*;
#(
    parameter int PREAMBLE_LEN = 7,
    parameter int IFG_BYTES    = 12,
    parameter int MAX_PAYLOAD  = 1514,
    parameter int CNT_W        = 16
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [7:0]       gmii_txd,
    output logic             gmii_tx_en,
    output logic             gmii_tx_er,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    // Byte counter must hold MAX_PAYLOAD+1 (saturation point) and MIN_PAYLOAD.
    localparam int BC_TOP = (MAX_PAYLOAD > MIN_PAYLOAD) ? MAX_PAYLOAD : MIN_PAYLOAD;
    localparam int BC_W   = $clog2(BC_TOP + 2);
    localparam logic [BC_W-1:0] BC_MAX = BC_W'(MAX_PAYLOAD);
`ifdef GMII_TX_PAD_EN
    localparam logic [BC_W-1:0] BC_MIN = BC_W'(MIN_PAYLOAD);
`endif
    // Shared counter: preamble bytes, FCS byte index, IFG cycles.
    localparam int CW = 16;

    tx_state_t        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BC_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0]      crc_q, crc_d;
    logic [7:0]       txd_q, txd_d;
    logic             tx_en_q, tx_en_d;
    logic             tx_er_q, tx_er_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             s_ready_c;

    logic [7:0]       crc_byte;
    logic [31:0]      crc_next;
    logic [31:0]      fcs;

    // Pad bytes are zeros; everything else hashed is the accepted payload byte.
    assign crc_byte = (state_q == ST_PAD) ? 8'h00 : s_data;
    assign fcs      = ~crc_q;

    crc32_d8 u_crc (
        .crc_in  (crc_q),
        .data    (crc_byte),
        .crc_out (crc_next)
    );

    // Next-state and next-wire-value logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        byte_cnt_d  = byte_cnt_q;
        crc_d       = crc_q;
        txd_d       = 8'h00;
        tx_en_d     = 1'b0;
        tx_er_d     = 1'b0;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        s_ready_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                crc_d      = CRC32_INIT;
                byte_cnt_d = '0;
                if (s_valid) begin
                    txd_d   = PREAMBLE_BYTE;
                    tx_en_d = 1'b1;
                    cnt_d   = CW'(1);
                    state_d = (PREAMBLE_LEN == 1) ? ST_SFD : ST_PREAMBLE;
                end
            end

            ST_PREAMBLE: begin
                txd_d   = PREAMBLE_BYTE;
                tx_en_d = 1'b1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(PREAMBLE_LEN - 1))
                    state_d = ST_SFD;
            end

            // SFD is registered here; the first payload byte is accepted while
            // it is on the wire so data follows without a gap.
            ST_SFD: begin
                txd_d   = SFD_BYTE;
                tx_en_d = 1'b1;
                state_d = ST_DATA;
            end

            ST_DATA: begin
                s_ready_c = 1'b1;
                if (!s_valid) begin
                    tx_en_d   = 1'b1;
                    tx_er_d   = 1'b1;
                    err_cnt_d = err_cnt_q + CNT_W'(1);
                    state_d   = ST_DROP;
                end else if (byte_cnt_q == BC_MAX) begin
                    // Oversize takes priority over s_last on the same byte.
                    tx_en_d    = 1'b1;
                    tx_er_d    = 1'b1;
                    err_cnt_d  = err_cnt_q + CNT_W'(1);
                    byte_cnt_d = BC_MAX + BC_W'(1);
                    cnt_d      = '0;
                    state_d    = s_last ? ST_IFG : ST_DROP;
                end else begin
                    txd_d      = s_data;
                    tx_en_d    = 1'b1;
                    crc_d      = crc_next;
                    byte_cnt_d = byte_cnt_q + BC_W'(1);
                    if (s_last) begin
                        cnt_d = '0;
`ifdef GMII_TX_PAD_EN
                        state_d = ((byte_cnt_q + BC_W'(1)) < BC_MIN) ? ST_PAD : ST_FCS;
`else
                        state_d = ST_FCS;
`endif
                    end
                end
            end

`ifdef GMII_TX_PAD_EN
            ST_PAD: begin
                tx_en_d    = 1'b1;
                crc_d      = crc_next;
                byte_cnt_d = byte_cnt_q + BC_W'(1);
                if (byte_cnt_q == BC_MIN - BC_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_FCS;
                end
            end
`endif

            ST_FCS: begin
                txd_d   = fcs[{cnt_q[1:0], 3'b000} +: 8];
                tx_en_d = 1'b1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q[1:0] == 2'd3) begin
                    frame_cnt_d = frame_cnt_q + CNT_W'(1);
                    cnt_d       = '0;
                    state_d     = ST_IFG;
                end
            end

            ST_IFG: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(IFG_BYTES - 1))
                    state_d = ST_IDLE;
            end

            ST_DROP: begin
                s_ready_c = 1'b1;
                if (s_valid && s_last) begin
                    cnt_d   = '0;
                    state_d = ST_IFG;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            byte_cnt_q  <= '0;
            crc_q       <= CRC32_INIT;
            txd_q       <= 8'h00;
            tx_en_q     <= 1'b0;
            tx_er_q     <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            crc_q       <= crc_d;
            txd_q       <= txd_d;
            tx_en_q     <= tx_en_d;
            tx_er_q     <= tx_er_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign s_ready    = s_ready_c;
    assign gmii_txd   = txd_q;
    assign gmii_tx_en = tx_en_q;
    assign gmii_tx_er = tx_er_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_cnt  = frame_cnt_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_gmii_frame_tx.sv
// Scoreboard bench for gmii_frame_tx (MAX_PAYLOAD=64 so oversize is reachable).
// Follows GMII_TX_PAD_EN to pick padded or unpadded expectations.
module tb_gmii_frame_tx;

    localparam int CNT_W = 16;
    localparam int MAXP  = 64;
    localparam int BOUND = 2000;

    logic             sys_clk = 1'b0;
    logic             rst_n   = 1'b0;
    logic [7:0]       s_data  = 8'h00;
    logic             s_valid = 1'b0;
    logic             s_last  = 1'b0;
    logic             s_ready;
    logic [7:0]       gmii_txd;
    logic             gmii_tx_en;
    logic             gmii_tx_er;
    logic             busy;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] err_cnt;

    always #4 sys_clk = ~sys_clk;

    gmii_frame_tx #(
        .PREAMBLE_LEN (7),
        .IFG_BYTES    (12),
        .MAX_PAYLOAD  (MAXP),
        .CNT_W        (CNT_W)
    ) dut (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .gmii_txd   (gmii_txd),
        .gmii_tx_en (gmii_tx_en),
        .gmii_tx_er (gmii_tx_er),
        .busy       (busy),
        .frame_cnt  (frame_cnt),
        .err_cnt    (err_cnt)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       er;
    } wexp_t;

    wexp_t exp_q[$];
    int    exp_len_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    exp_frames = 0;
    int    exp_errs   = 0;
    int    burst = 0;
    int    gap   = 0;
    int    last_gap = 0;
    bit    chk_gap_ready = 1'b0;
    int    gap_ready_viol = 0;
    wexp_t mon_e;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: pops one expected wire byte per tx_en cycle, checks burst lengths.
    always @(negedge sys_clk) begin
        if (gmii_tx_en) begin
            if (burst == 0) last_gap = gap;
            gap = 0;
            burst++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL wire_extra: got txd=0x%0h er=%0b expected no transmission", gmii_txd, gmii_tx_er);
            end else begin
                mon_e = exp_q.pop_front();
                check("wire_byte", {23'b0, gmii_txd, gmii_tx_er}, {23'b0, mon_e});
            end
        end else begin
            if (burst > 0) begin
                if (exp_len_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL burst_extra: got burst of %0d expected none", burst);
                end else begin
                    check("burst_len", 32'(burst), 32'(exp_len_q.pop_front()));
                end
                burst = 0;
            end
            gap++;
            check("idle_er", {31'b0, gmii_tx_er}, 32'd0);
            if (chk_gap_ready && s_ready) gap_ready_viol++;
        end
    end

    function automatic logic [31:0] crc_model(input logic [7:0] d[$]);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (d[i]) begin
            c = c ^ {24'h0, d[i]};
            for (int b = 0; b < 8; b++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic push_pre();
        for (int i = 0; i < 7; i++) exp_q.push_back('{d: 8'h55, er: 1'b0});
        exp_q.push_back('{d: 8'hD5, er: 1'b0});
    endtask

    task automatic push_good(input logic [7:0] p[$]);
        logic [7:0]  q[$];
        logic [31:0] f;
        q = p;
`ifdef GMII_TX_PAD_EN
        while (q.size() < 60) q.push_back(8'h00);
`endif
        f = crc_model(q);
        push_pre();
        foreach (q[i]) exp_q.push_back('{d: q[i], er: 1'b0});
        for (int i = 0; i < 4; i++) exp_q.push_back('{d: f[8*i +: 8], er: 1'b0});
        exp_len_q.push_back(8 + q.size() + 4);
        exp_frames++;
    endtask

    task automatic push_err(input logic [7:0] p[$], input int n_sent);
        push_pre();
        for (int i = 0; i < n_sent; i++) exp_q.push_back('{d: p[i], er: 1'b0});
        exp_q.push_back('{d: 8'h00, er: 1'b1});
        exp_len_q.push_back(8 + n_sent + 1);
        exp_errs++;
    endtask

    // "123456789": unpadded build uses the published check value directly.
    task automatic push_123(input logic [7:0] p[$]);
`ifdef GMII_TX_PAD_EN
        push_good(p);
`else
        push_pre();
        foreach (p[i]) exp_q.push_back('{d: p[i], er: 1'b0});
        exp_q.push_back('{d: 8'h26, er: 1'b0});
        exp_q.push_back('{d: 8'h39, er: 1'b0});
        exp_q.push_back('{d: 8'hF4, er: 1'b0});
        exp_q.push_back('{d: 8'hCB, er: 1'b0});
        exp_len_q.push_back(21);
        exp_frames++;
`endif
    endtask

    // Stream bytes; optional stall before byte stall_at; optional early return
    // (s_valid left high) after abort_after accepted bytes.
    task automatic send(input logic [7:0] p[$], input int stall_at, input int stall_cyc,
                        input int abort_after);
        int t;
        for (int i = 0; i < p.size(); i++) begin
            if (i == stall_at && stall_cyc > 0) begin
                @(negedge sys_clk);
                s_valid = 1'b0;
                s_last  = 1'b0;
                repeat (stall_cyc - 1) @(negedge sys_clk);
            end
            @(negedge sys_clk);
            s_valid = 1'b1;
            s_data  = p[i];
            s_last  = (i == p.size() - 1);
            t = 0;
            while (!s_ready && t < BOUND) begin
                @(negedge sys_clk);
                t++;
            end
            if (t >= BOUND) begin
                n_tests++;
                n_fail++;
                $display("FAIL handshake_timeout: byte %0d not accepted in %0d cycles", i, BOUND);
                s_valid = 1'b0;
                s_last  = 1'b0;
                return;
            end
            @(posedge sys_clk);
            if (abort_after > 0 && i + 1 == abort_after) return;
        end
        @(negedge sys_clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge sys_clk);
        while (busy && t < BOUND) begin
            @(negedge sys_clk);
            t++;
        end
        if (t >= BOUND) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: busy still 1 after %0d cycles", BOUND);
        end
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_frames));
        check({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_errs));
        check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_len_empty"}, 32'(exp_len_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] p[$];

        // Reset state
        repeat (3) @(negedge sys_clk);
        check("rst_txd", 32'(gmii_txd), 32'd0);
        check("rst_en", 32'(gmii_tx_en), 32'd0);
        check("rst_er", 32'(gmii_tx_er), 32'd0);
        check("rst_ready", 32'(s_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        // CRC check-value frame
        p = {};
        for (int i = 0; i < 9; i++) p.push_back(8'(8'h31 + i));
        push_123(p);
        send(p, -1, 0, 0);
        wait_idle();
        check_counters("t1");

        // Short frame 0x00..0x09 (padded to 60 in the pad build)
        p = {};
        for (int i = 0; i < 10; i++) p.push_back(8'(i));
        push_good(p);
        send(p, -1, 0, 0);
        wait_idle();
        check_counters("t2");

        // Two back-to-back 64-byte frames: exact IFG, s_ready low in the gap
        p = {};
        for (int i = 0; i < 64; i++) p.push_back(8'(i * 3 + 1));
        push_good(p);
        push_good(p);
        gap_ready_viol = 0;
        chk_gap_ready  = 1'b1;
        send(p, -1, 0, 0);
        send(p, -1, 0, 0);
        wait_idle();
        chk_gap_ready = 1'b0;
        check("ifg_gap", 32'(last_gap), 32'd12);
        check("ready_in_ifg", 32'(gap_ready_viol), 32'd0);
        check_counters("t3");

        // Underrun after 20 bytes, 10 more bytes dropped
        p = {};
        for (int i = 0; i < 30; i++) p.push_back(8'(8'hA0 + i));
        push_err(p, 20);
        send(p, 20, 3, 0);
        wait_idle();
        check_counters("t4");

        // Oversize: 70 bytes with MAX_PAYLOAD=64
        p = {};
        for (int i = 0; i < 70; i++) p.push_back(8'(8'h80 ^ i));
        push_err(p, 64);
        send(p, -1, 0, 0);
        wait_idle();
        check_counters("t5");

        // Oversize byte also carries s_last: still an error, straight to IFG
        p = {};
        for (int i = 0; i < 65; i++) p.push_back(8'(8'hF0 - i));
        push_err(p, 64);
        send(p, -1, 0, 0);
        wait_idle();
        check_counters("t6");

        // Exactly MAX_PAYLOAD bytes is a good frame
        p = {};
        for (int i = 0; i < 64; i++) p.push_back(8'(8'h5A ^ (i * 7)));
        push_good(p);
        send(p, -1, 0, 0);
        wait_idle();
        check_counters("t6b");

        // Reset for one cycle in DATA after 10 bytes
        p = {};
        for (int i = 0; i < 30; i++) p.push_back(8'(8'h10 + i));
        push_pre();
        for (int i = 0; i < 10; i++) exp_q.push_back('{d: p[i], er: 1'b0});
        exp_len_q.push_back(18);
        send(p, -1, 0, 10);
        @(negedge sys_clk);
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(negedge sys_clk);
        check("mrst_en", 32'(gmii_tx_en), 32'd0);
        check("mrst_er", 32'(gmii_tx_er), 32'd0);
        check("mrst_ready", 32'(s_ready), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        exp_frames = 0;
        exp_errs   = 0;
        rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        check_counters("t7");

        // Clean frame after the mid-frame reset
        p = {};
        for (int i = 0; i < 9; i++) p.push_back(8'(8'h31 + i));
        push_123(p);
        send(p, -1, 0, 0);
        wait_idle();
        check_counters("t8");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
